// File: rtl/pwm_dac.sv
// PWM DAC: a free-running WIDTH-bit counter compared against a duty register that is
// double-buffered so duty only changes on period boundaries.
module pwm_dac #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic             sample_ready,
  output logic             pwm_out,
  output logic             period_start,
  output logic             underrun,
  output logic [7:0]       underrun_count
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_reg;
  logic [WIDTH-1:0] active_reg;
  logic [WIDTH-1:0] pending_reg;
  logic             pending_full_reg;
  logic             pwm_reg;
  logic             underrun_reg;
  logic [7:0]       underrun_count_reg;

  logic accept;
  logic boundary;

  assign sample_ready   = !pending_full_reg && !reset;
  assign accept         = sample_valid && sample_ready;
  assign boundary       = (cnt_reg == CNT_MAX);
  assign period_start   = (cnt_reg == '0) && !reset;
  assign pwm_out        = pwm_reg;
  assign underrun       = underrun_reg;
  assign underrun_count = underrun_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg            <= '0;
      active_reg         <= '0;
      pending_reg        <= '0;
      pending_full_reg   <= 1'b0;
      pwm_reg            <= 1'b0;
      underrun_reg       <= 1'b0;
      underrun_count_reg <= 8'd0;
    end else begin
      cnt_reg      <= cnt_reg + 1'b1;
      pwm_reg      <= (cnt_reg < active_reg);
      underrun_reg <= 1'b0;
      if (boundary) begin
        // pending_full forces sample_ready low, so an accept here only happens when empty
        if (pending_full_reg) begin
          active_reg       <= pending_reg;
          pending_full_reg <= 1'b0;
        end else if (accept) begin
          active_reg <= sample_in;
        end else begin
          underrun_reg <= 1'b1;
          if (underrun_count_reg != 8'hFF) begin
            underrun_count_reg <= underrun_count_reg + 8'd1;
          end
        end
      end else if (accept) begin
        pending_reg      <= sample_in;
        pending_full_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac at WIDTH=6 (64-cycle period) so the long underrun run stays short;
// duty values from the 1024-cycle scenarios are scaled to the 64-cycle period.
module tb_pwm_dac;

  localparam int W = 6;
  localparam int P = 1 << W;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sample_in;
  logic         sample_valid;
  logic         sample_ready;
  logic         pwm_out;
  logic         period_start;
  logic         underrun;
  logic [7:0]   underrun_count;

  int compared   = 0;
  int mismatched = 0;

  // reference model state: cycle position, duty in use, one-deep pending queue
  int   m_cnt, m_active, m_uc;
  int   pend[$];
  logic m_pwm, m_und;

  // per-period duty measurement from the observed pin
  int   hi_run, per_active, last_high;
  bit   win_valid;
  int   und_seen;
  logic obs_ps, obs_ready, obs_pwm;
  bit   last_acc;
  int   base;

  pwm_dac #(.WIDTH(W)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .sample_ready  (sample_ready),
    .pwm_out       (pwm_out),
    .period_start  (period_start),
    .underrun      (underrun),
    .underrun_count(underrun_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic rst, input logic v, input logic [W-1:0] s);
    logic exp_ready, exp_ps;
    bit   acc;
    reset        = rst;
    sample_valid = v;
    sample_in    = s;
    @(negedge clk);
    exp_ready = !rst && (pend.size() == 0);
    exp_ps    = !rst && (m_cnt == 0);
    obs_ps    = period_start;
    obs_ready = sample_ready;
    obs_pwm   = pwm_out;
    chk("sample_ready", sample_ready, exp_ready);
    chk("period_start", period_start, exp_ps);
    chk("pwm_out", pwm_out, m_pwm);
    chk("underrun", underrun, m_und);
    chk("underrun_count", underrun_count, m_uc);
    if (underrun === 1'b1) und_seen++;
    if (rst) begin
      win_valid = 0;
    end else begin
      // pin at cnt=k+1 reflects compare at cnt=k, so a period's window is cnt 1..63 then 0
      if (m_cnt == 1) begin
        hi_run     = (pwm_out === 1'b1) ? 1 : 0;
        per_active = m_active;
        win_valid  = 1;
      end else begin
        hi_run += (pwm_out === 1'b1) ? 1 : 0;
      end
      if (m_cnt == 0 && win_valid) begin
        last_high = hi_run;
        chk("period_duty", hi_run, per_active);
      end
    end
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt = 0; m_active = 0; pend.delete(); m_pwm = 0; m_und = 0; m_uc = 0;
    end else begin
      m_pwm = (m_cnt < m_active);
      m_und = 0;
      if (m_cnt == P - 1) begin
        if (pend.size() > 0) m_active = pend.pop_front();
        else if (acc) m_active = int'(s);
        else begin
          m_und = 1;
          if (m_uc < 255) m_uc++;
        end
      end else if (acc) begin
        pend.push_back(int'(s));
      end
      m_cnt = (m_cnt + 1) % P;
    end
    last_acc = acc;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, '0);
  endtask

  task automatic send(input logic [W-1:0] s);
    bit done;
    done = 0;
    for (int i = 0; i < 3 * P && !done; i++) begin
      tick(1'b0, 1'b1, s);
      done = last_acc;
    end
    sample_valid = 1'b0;
    chk("send_accepted", done, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
    m_cnt = 0; m_active = 0; m_uc = 0; m_pwm = 0; m_und = 0;
    win_valid = 0; und_seen = 0; hi_run = 0; per_active = 0; last_high = -1;
    @(posedge clk); #1;

    // reset state, then a held sample of half scale accepted at cnt 0
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, '0);
    chk("reset_ready", obs_ready, 0);
    chk("reset_period_start", obs_ps, 0);
    chk("reset_pwm", obs_pwm, 0);
    tick(1'b0, 1'b1, 6'd32);
    chk("rel_period_start", obs_ps, 1);
    chk("rel_accept_cycle0", last_acc, 1);
    for (int i = 0; i < 2 * P; i++) tick(1'b0, 1'b1, 6'd32);
    chk("half_duty", last_high, 32);

    // minimum then maximum duty on successive periods
    send(6'd0);
    send(6'd63);
    run(P);
    chk("zero_duty", last_high, 0);
    run(P);
    chk("max_duty", last_high, 63);

    // second sample held while pending is full: taken at period start, no loss
    send(6'd10);
    send(6'd11);
    chk("held_accept_at_start", obs_ps, 1);
    run(P);
    chk("held_first", last_high, 10);
    run(P);
    chk("held_second", last_high, 11);

    // bypass: valid only in the boundary cycle with pending empty
    run(P);
    for (int i = 0; i < 2 * P && m_cnt != P - 1; i++) tick(1'b0, 1'b0, '0);
    base = und_seen;
    tick(1'b0, 1'b1, 6'd16);
    chk("bypass_accept", last_acc, 1);
    tick(1'b0, 1'b0, '0);
    chk("bypass_no_underrun", und_seen - base, 0);
    run(P);
    chk("bypass_duty", last_high, 16);

    // starvation: 300 idle periods keep duty and saturate the counter
    send(6'd25);
    for (int i = 0; i < 2 * P && !(m_cnt == 0 && m_active == 25); i++) tick(1'b0, 1'b0, '0);
    base = und_seen;
    run(300 * P + 1);
    chk("starve_pulses", und_seen - base, 300);
    chk("starve_count_sat", underrun_count, 255);
    chk("starve_duty", last_high, 25);

    // reset mid-period with pending full abandons the pending sample
    for (int i = 0; i < 2 * P && m_cnt != 10; i++) tick(1'b0, 1'b0, '0);
    send(6'd5);
    for (int i = 0; i < 2 * P && m_cnt != 37; i++) tick(1'b0, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b1, 1'b0, '0);
    tick(1'b0, 1'b0, '0);
    chk("post_reset_period_start", obs_ps, 1);
    chk("post_reset_ready", obs_ready, 1);
    chk("post_reset_pwm", obs_pwm, 0);
    chk("post_reset_count", underrun_count, 0);
    run(P);
    chk("post_reset_duty1", last_high, 0);
    run(P);
    chk("post_reset_pending_dropped", last_high, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      logic r, v;
      logic [W-1:0] s;
      r = ($urandom_range(0, 499) == 0);
      v = ($urandom_range(0, 2) == 0);
      s = W'($urandom);
      tick(r, v, s);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
